// File: rtl/led_display_scheduler.sv
// led_display_scheduler
// Scans two 4-digit multiplexed 7-segment displays. It owns the LED IO
// registers (LED_CTRL at 5'h3, LED0..LED7 at 5'h8..5'hf). It latches a
// hex-encoded frame once per scan frame, so the display never tears, and
// then steps through the digits with a programmable dwell counter.
// Optional build macro: LED_DD_BLANK_EN enables leading-zero blanking in
// mode 0 (sort result) at latch time.
module led_display_scheduler #(
   parameter logic [27:0] SCAN_COUNT = 28'h3000,
   parameter int          DIGIT_NUM  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wrEnable,
   input  logic [4:0]  wrAddr,
   input  logic [31:0] wrData,
   input  logic [31:0] sortCount,
   input  logic [31:0] cycle,
   output logic [15:0] ledOut,
   output logic [7:0]  ledGate,
   output logic        ledCtrl,
   output logic        frameDone
);

   localparam logic [1:0] LAST_DIGIT = 2'(DIGIT_NUM - 1);

`ifdef LED_DD_BLANK_EN
   localparam logic BLANK_EN = 1'b1;
`else
   localparam logic BLANK_EN = 1'b0;
`endif

   // 7-segment encoding, {dp,g,f,e,d,c,b,a}; dp is never lit
   function automatic logic [7:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 8'h3F;
         4'h1: hex7 = 8'h06;
         4'h2: hex7 = 8'h5B;
         4'h3: hex7 = 8'h4F;
         4'h4: hex7 = 8'h66;
         4'h5: hex7 = 8'h6D;
         4'h6: hex7 = 8'h7D;
         4'h7: hex7 = 8'h07;
         4'h8: hex7 = 8'h7F;
         4'h9: hex7 = 8'h6F;
         4'hA: hex7 = 8'h77;
         4'hB: hex7 = 8'h7C;
         4'hC: hex7 = 8'h39;
         4'hD: hex7 = 8'h5E;
         4'hE: hex7 = 8'h79;
         default: hex7 = 8'h71;
      endcase
   endfunction

   // Four nibbles (digit 0 in the top nibble) to a frame word (digit 0 in
   // the top byte). With blank set, digits left of the first nonzero
   // nibble come out dark; the rightmost digit always shows.
   function automatic logic [31:0] build_frame(input logic [15:0] nibs,
                                               input logic        blank);
      logic seen;
      seen        = ~blank;
      build_frame = '0;
      for (int i = 0; i < 4; i++) begin
         if (nibs[15-4*i -: 4] != 4'h0 || i == 3) seen = 1'b1;
         if (seen) build_frame[31-8*i -: 8] = hex7(nibs[15-4*i -: 4]);
      end
   endfunction

   // Pick the segment byte of one digit out of a frame word
   function automatic logic [7:0] digit_sel(input logic [31:0] f,
                                            input logic [1:0]  i);
      case (i)
         2'd0:    digit_sel = f[31:24];
         2'd1:    digit_sel = f[23:16];
         2'd2:    digit_sel = f[15:8];
         default: digit_sel = f[7:0];
      endcase
   endfunction

   logic [27:0]     r_scan;
   logic [1:0]      r_idx;
   logic            r_mode;
   logic [7:0][3:0] r_nib;
   logic [31:0]     r_frame0, r_frame1;
   logic [15:0]     r_ledOut;
   logic [7:0]      r_ledGate;
   logic            r_frameDone;

   logic        w_scanWrap;
   logic [27:0] w_scanNext;
   logic [1:0]  w_idxNext;
   logic        w_boundary;
   logic        w_blank;
   logic [31:0] w_src0, w_src1;
   logic [31:0] w_frame0Next, w_frame1Next;
   logic [3:0]  w_gateNext;
   logic        w_unused_bits;

   // Dwell counter and digit index next-state; the boundary is the 3->0 wrap
   always_comb begin
      w_scanWrap = (r_scan == SCAN_COUNT - 28'd1);
      w_scanNext = w_scanWrap ? 28'd0 : r_scan + 28'd1;
      w_idxNext  = w_scanWrap ? r_idx + 2'd1 : r_idx;
      w_boundary = w_scanWrap && (r_idx == LAST_DIGIT);
      w_gateNext = 4'b0001 << w_idxNext;
   end

   // Frame source selection and encoding, using the mode in force before
   // this edge so that a same-cycle write lands one frame later
   always_comb begin
      w_blank = BLANK_EN & ~r_mode;
      if (r_mode) begin
         w_src0 = build_frame({r_nib[0], r_nib[1], r_nib[2], r_nib[3]}, 1'b0);
         w_src1 = build_frame({r_nib[4], r_nib[5], r_nib[6], r_nib[7]}, 1'b0);
      end else begin
         w_src0 = build_frame(sortCount[15:0], w_blank);
         w_src1 = build_frame(cycle[31:16], w_blank);
      end
      w_frame0Next = w_boundary ? w_src0 : r_frame0;
      w_frame1Next = w_boundary ? w_src1 : r_frame1;
   end

   // Input bits that do not feed any display data
   assign w_unused_bits = &{1'b0, wrData[31:4], sortCount[31:16], cycle[15:0]};

   // IO register writes: LED_CTRL mode bit and the eight user nibbles
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mode <= 1'b0;
         r_nib  <= '0;
      end else if (wrEnable) begin
         if (wrAddr == 5'h03)
            r_mode <= wrData[0];
         else if (wrAddr[4:3] == 2'b01)
            r_nib[wrAddr[2:0]] <= wrData[3:0];
      end
   end

   // Scan sequencing, frame latching and registered display outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_scan      <= '0;
         r_idx       <= '0;
         r_frame0    <= '0;
         r_frame1    <= '0;
         r_ledOut    <= 16'h0000;
         r_ledGate   <= 8'h11;
         r_frameDone <= 1'b0;
      end else begin
         r_scan      <= w_scanNext;
         r_idx       <= w_idxNext;
         r_frame0    <= w_frame0Next;
         r_frame1    <= w_frame1Next;
         r_frameDone <= w_boundary;
         r_ledGate   <= {w_gateNext, w_gateNext};
         r_ledOut    <= {digit_sel(w_frame1Next, w_idxNext),
                         digit_sel(w_frame0Next, w_idxNext)};
      end
   end

   assign ledOut    = r_ledOut;
   assign ledGate   = r_ledGate;
   assign ledCtrl   = r_mode;
   assign frameDone = r_frameDone;

endmodule

// File: tb/tb_led_display_scheduler.sv
// tb_led_display_scheduler
// Table vectors, hand-written corner sequences and random traffic, all
// checked against a cycle-count based model of the display scheduler.
module tb_led_display_scheduler;

   localparam int SC    = 4;
   localparam int FRAME = 4 * SC;
   localparam logic [127:0] SEGS = 128'h3F065B4F666D7D077F6F777C395E7971;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wrEnable = 1'b0;
   logic [4:0]  wrAddr = '0;
   logic [31:0] wrData = '0;
   logic [31:0] sortCount = '0;
   logic [31:0] cycle = '0;
   logic [15:0] ledOut;
   logic [7:0]  ledGate;
   logic        ledCtrl;
   logic        frameDone;

   always #5 clk = ~clk;

   led_display_scheduler #(.SCAN_COUNT(28'(SC)), .DIGIT_NUM(4)) dut (
      .clk(clk), .rst(rst), .wrEnable(wrEnable), .wrAddr(wrAddr),
      .wrData(wrData), .sortCount(sortCount), .cycle(cycle),
      .ledOut(ledOut), .ledGate(ledGate), .ledCtrl(ledCtrl),
      .frameDone(frameDone)
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   // t = clock edges since reset release; everything else follows from it
   int         t;
   logic       m_mode;
   logic [3:0] m_nib [8];
   logic [7:0] m_f0 [4];
   logic [7:0] m_f1 [4];

   function automatic logic [7:0] enc(input logic [3:0] n);
      logic [127:0] s;
      s = SEGS;
      return s[127 - 8*int'(n) -: 8];
   endfunction

   function automatic logic [7:0] dig(input logic [31:0] w, input int i);
      logic [31:0] x;
      x = w >> (8 * (3 - i));
      return x[7:0];
   endfunction

   task automatic model_reset();
      t = 0;
      m_mode = 1'b0;
      for (int j = 0; j < 8; j++) m_nib[j] = 4'h0;
      for (int i = 0; i < 4; i++) begin m_f0[i] = 8'h00; m_f1[i] = 8'h00; end
   endtask

   task automatic model_latch(input logic [31:0] sc, input logic [31:0] cy);
      logic [3:0] n;
      logic       lead;
      logic       blank_on;
      logic [7:0] b;
`ifdef LED_DD_BLANK_EN
      blank_on = ~m_mode;
`else
      blank_on = 1'b0;
`endif
      for (int d = 0; d < 2; d++) begin
         lead = 1'b1;
         for (int i = 0; i < 4; i++) begin
            if (m_mode) n = m_nib[4*d + i];
            else if (d == 0) n = 4'((sc >> (12 - 4*i)) & 32'hF);
            else n = 4'((cy >> (28 - 4*i)) & 32'hF);
            if (blank_on && lead && i < 3 && n == 4'h0) b = 8'h00;
            else begin b = enc(n); lead = 1'b0; end
            if (d == 0) m_f0[i] = b; else m_f1[i] = b;
         end
      end
   endtask

   task automatic model_step(input logic we, input logic [4:0] a, input logic [31:0] d,
                             input logic [31:0] sc, input logic [31:0] cy);
      t++;
      if (t % FRAME == 0) model_latch(sc, cy);
      if (we) begin
         if (a == 5'h03) m_mode = d[0];
         else if (a >= 5'h08 && a <= 5'h0f) m_nib[a - 5'h08] = d[3:0];
      end
   endtask

   task automatic cmp_model();
      int         idx;
      logic [3:0] g;
      idx = (t / SC) % 4;
      g = 4'b0001 << idx;
      chk("ledGate", {24'h0, ledGate}, {24'h0, g, g});
      chk("ledOut", {16'h0, ledOut}, {16'h0, m_f1[idx], m_f0[idx]});
      chk("frameDone", {31'h0, frameDone}, {31'h0, (t > 0 && t % FRAME == 0)});
      chk("ledCtrl", {31'h0, ledCtrl}, {31'h0, m_mode});
   endtask

   // One clock: drive at negedge, step the model, compare at the next negedge
   task automatic tick(input logic we, input logic [4:0] a, input logic [31:0] d);
      wrEnable = we; wrAddr = a; wrData = d;
      model_step(we, a, d, sortCount, cycle);
      @(posedge clk);
      @(negedge clk);
      wrEnable = 1'b0;
      cmp_model();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick(1'b0, 5'h0, 32'h0);
   endtask

   task automatic wait_fd(input string nm);
      int k;
      k = 0;
      do begin idle(1); k++; end while (frameDone !== 1'b1 && k < 2*FRAME);
      chk(nm, {31'h0, frameDone}, 32'h1);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        mode;
      logic [31:0] sc;
      logic [31:0] cy;
      logic [31:0] nibs;   // LED0 in bits [31:28] .. LED7 in bits [3:0]
      logic [31:0] e0;     // expected display0 bytes, digit 0 in the top byte
      logic [31:0] e1;
   } vec_t;

   vec_t vecs [5];

   task automatic apply_vec(input int vi, input vec_t v);
      logic [31:0] dw;
      wait_fd($sformatf("v%0d sync", vi));
      tick(1'b1, 5'h03, {31'h0, v.mode});
      chk($sformatf("v%0d ledCtrl now", vi), {31'h0, ledCtrl}, {31'h0, v.mode});
      if (v.mode) begin
         for (int j = 0; j < 8; j++) begin
            dw = v.nibs >> (4 * (7 - j));
            tick(1'b1, 5'(8 + j), {28'h0, dw[3:0]});
         end
      end
      sortCount = v.sc;
      cycle     = v.cy;
      wait_fd($sformatf("v%0d frame", vi));
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("v%0d disp0 d%0d", vi, i), {24'h0, ledOut[7:0]},  {24'h0, dig(v.e0, i)});
         chk($sformatf("v%0d disp1 d%0d", vi, i), {24'h0, ledOut[15:8]}, {24'h0, dig(v.e1, i)});
         if (i < 3) idle(SC);
      end
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      vecs[0] = '{1'b0, 32'h0000_1234, 32'hABCD_0000, 32'h0, 32'h065B4F66, 32'h777C395E};
`ifdef LED_DD_BLANK_EN
      vecs[1] = '{1'b0, 32'h0000_0007, 32'hFFFF_1234, 32'h0, 32'h00000007, 32'h71717171};
      vecs[2] = '{1'b0, 32'hFFFF_0000, 32'h8000_0000, 32'h0, 32'h0000003F, 32'h7F3F3F3F};
`else
      vecs[1] = '{1'b0, 32'h0000_0007, 32'hFFFF_1234, 32'h0, 32'h3F3F3F07, 32'h71717171};
      vecs[2] = '{1'b0, 32'hFFFF_0000, 32'h8000_0000, 32'h0, 32'h3F3F3F3F, 32'h7F3F3F3F};
`endif
      vecs[3] = '{1'b1, 32'h0, 32'h0, 32'h9ABCDEF0, 32'h6F777C39, 32'h5E79713F};
      vecs[4] = '{1'b1, 32'h0, 32'h0, 32'h01234567, 32'h3F065B4F, 32'h666D7D07};

      // Reset state
      repeat (2) @(negedge clk);
      chk("reset ledGate", {24'h0, ledGate}, 32'h11);
      chk("reset ledOut", {16'h0, ledOut}, 32'h0);
      chk("reset ledCtrl", {31'h0, ledCtrl}, 32'h0);
      chk("reset frameDone", {31'h0, frameDone}, 32'h0);
      rst = 1'b1;
      model_reset();

      for (int vi = 0; vi < 5; vi++) apply_vec(vi, vecs[vi]);

      // Write on the boundary edge is not part of the frame latched there
      k = 0;
      while ((t + 1) % FRAME != 0 && k < FRAME) begin idle(1); k++; end
      tick(1'b1, 5'h08, 32'h9);
      chk("bwr frameDone", {31'h0, frameDone}, 32'h1);
      chk("bwr old digit", {24'h0, ledOut[7:0]}, 32'h3F);
      wait_fd("bwr next frame");
      chk("bwr new digit", {24'h0, ledOut[7:0]}, 32'h6F);

      // Unmapped addresses change nothing
      tick(1'b1, 5'h10, 32'h0000_000E);
      tick(1'b1, 5'h00, 32'h0000_000E);
      tick(1'b1, 5'h04, 32'h0000_000E);
      wait_fd("unmapped frame");
      chk("unmapped digit", {24'h0, ledOut[7:0]}, 32'h6F);
      chk("unmapped ctrl", {31'h0, ledCtrl}, 32'h1);

      // Asynchronous reset in the middle of a frame (digit 2 lit)
      k = 0;
      while (ledGate !== 8'h44 && k < 2*FRAME) begin idle(1); k++; end
      chk("reached digit 2", {24'h0, ledGate}, 32'h44);
      #2 rst = 1'b0;
      #1;
      chk("midreset ledGate", {24'h0, ledGate}, 32'h11);
      chk("midreset ledOut", {16'h0, ledOut}, 32'h0);
      chk("midreset ledCtrl", {31'h0, ledCtrl}, 32'h0);
      chk("midreset frameDone", {31'h0, frameDone}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      sortCount = 32'h0000_4321;
      cycle     = 32'h5678_0000;
      k = 0;
      do begin idle(1); k++; end while (frameDone !== 1'b1 && k < 3*FRAME);
      chk("first frameDone cycle", k, FRAME);

      // Random traffic against the model
      for (int n = 0; n < 700; n++) begin
         logic [4:0] a;
         logic       we;
         case ($urandom_range(0, 3))
            0: a = 5'h03;
            1, 2: a = 5'(8 + $urandom_range(0, 7));
            default: a = 5'($urandom_range(0, 31));
         endcase
         we = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 2) == 0) sortCount = $urandom;
         if ($urandom_range(0, 2) == 0) cycle = $urandom;
         if ($urandom_range(0, 4) == 0) sortCount = $urandom_range(0, 15);
         tick(we, a, $urandom);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
